// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int unsigned REG_ADDR_W           = 5;
  localparam int unsigned DATA_W               = 32;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  // One queued MDU result; live drops when a younger pipeline write kills it.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order queue of MDU results with per-entry live flag and
// address-match kill. Slot 0 is always the head.
module wb_fifo2
  import wb_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_addr_i,
  output logic                  head_live_o,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0]     head_data_o,
  output logic [1:0]            count_o
);

  wb_entry_t  slot0_q, slot0_d;
  wb_entry_t  slot1_q, slot1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok, pop_ok;
  logic [1:0] wr_idx;
  wb_entry_t  new_ent;

  // Next-state: kill stored entries first, then shift on pop, then place the push.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    push_ok = push_i && (cnt_q != 2'd2);
    pop_ok  = pop_i && (cnt_q != 2'd0);

    if (kill_i && (slot0_q.addr == kill_addr_i)) slot0_d.live = 1'b0;
    if (kill_i && (slot1_q.addr == kill_addr_i)) slot1_d.live = 1'b0;

    if (pop_ok) begin
      slot0_d = slot1_d;
      slot1_d = '0;
    end

    // An entry pushed alongside a matching kill is older than the pipe write.
    new_ent.live = !(kill_i && (kill_addr_i == push_addr_i));
    new_ent.addr = push_addr_i;
    new_ent.data = push_data_i;

    wr_idx = pop_ok ? (cnt_q - 2'd1) : cnt_q;
    if (push_ok) begin
      if (wr_idx == 2'd0) slot0_d = new_ent;
      else                slot1_d = new_ent;
    end

    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_live_o = slot0_q.live;
  assign head_addr_o = slot0_q.addr;
  assign head_data_o = slot0_q.data;
  assign count_o     = cnt_q;

endmodule

// File: rtl/wb_port_arb.sv
// Arbitrates the single register-file write port between the main pipeline
// and queued MDU results, forcing an MDU write when a result starves.
module wb_port_arb
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0]     pipe_data,
  output logic                  pipe_ready,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0]     wData,
  output logic [1:0]            pend_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  pipe_acc, mdu_push, q_pop, kill;
  logic                  head_live;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0]     head_data;

  wb_fifo2 u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (mdu_push),
    .push_addr_i (mdu_addr),
    .push_data_i (mdu_data),
    .pop_i       (q_pop),
    .kill_i      (kill),
    .kill_addr_i (pipe_addr),
    .head_live_o (head_live),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (pend_cnt)
  );

  // Grant selection, starvation tracking and FSM next state.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pipe_ready = (state_q == NORMAL);
    mdu_ready  = (pend_cnt != 2'd2);
    pipe_acc   = pipe_valid && pipe_ready;
    mdu_push   = mdu_valid && mdu_ready;
    kill       = pipe_acc && (pipe_addr != '0);
    q_pop      = (pend_cnt != 2'd0) && ((state_q == FORCE) || !pipe_valid);

    if (pipe_acc) begin
      we_d    = (pipe_addr != '0);
      waddr_d = pipe_addr;
      wdata_d = pipe_data;
    end else if (q_pop) begin
      we_d    = head_live && (head_addr != '0);
      waddr_d = head_addr;
      wdata_d = head_data;
    end

    if ((pend_cnt == 2'd0) || q_pop) starve_d = '0;
    else if (starve_q != LIMIT)      starve_d = starve_q + 4'd1;

    // Entering FORCE off the counter's next value means the head waits exactly
    // STARVE_LIMIT cycles, and the queue is guaranteed non-empty in FORCE.
    case (state_q)
      NORMAL:  if (starve_d == LIMIT) state_d = FORCE;
      FORCE:   state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Registered write port, starve counter and arbiter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign we    = we_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;

endmodule
